// File: rtl/pwm_pkg.sv
// Shared state encoding and default constants for the PWM duty-ramp controller slice.
package pwm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    STEP  = 3'd2,
    DWELL = 3'd3,
    DONE  = 3'd4
  } pwm_state_e;

  localparam int PWM_PERIOD     = 10;
  localparam int PWM_DUTY_MAX   = 10;
  localparam int PWM_DUTY_RESET = 5;

endpackage

// File: rtl/pwm_period_tick.sv
// Free-running modulo-PERIOD counter; tick marks the last count of each PWM period.
module pwm_period_tick
  import pwm_pkg::*;
#(
  parameter int PERIOD = PWM_PERIOD
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_r;

  // Period phase counter, wraps after LAST
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Walks pwm_generator's duty toward a requested target, one step per STEP_DIV periods.
// Define PWM_RAMP_RETARGET_EN to accept a new target while a ramp is aligning or dwelling.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int PERIOD     = PWM_PERIOD,
  parameter int DUTY_MAX   = PWM_DUTY_MAX,
  parameter int DUTY_RESET = PWM_DUTY_RESET,
  parameter int STEP_DIV   = 2,
  parameter int DW         = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tgt_valid,
  output logic          tgt_ready,
  input  logic [DW-1:0] tgt_duty,
  output logic          increase_duty,
  output logic          decrease_duty,
  output logic          pwm_reset,
  output logic [DW-1:0] cur_duty,
  output logic          busy,
  output logic          done,
  output logic          clamped
);

`ifdef PWM_RAMP_RETARGET_EN
  localparam logic RETARGET = 1'b1;
`else
  localparam logic RETARGET = 1'b0;
`endif

  localparam int            SW         = $clog2(STEP_DIV + 1);
  localparam logic [DW-1:0] DMAX       = DW'(DUTY_MAX);
  localparam logic [DW-1:0] DRST       = DW'(DUTY_RESET);
  localparam logic [SW-1:0] DWELL_LAST = SW'(STEP_DIV - 1);

  pwm_state_e    state_r;
  logic [DW-1:0] cur_r, tgt_r, req_s, eff_tgt_s;
  logic [SW-1:0] dwell_r;
  logic          tick_s, xfer_s, over_s, hit_s, up_s;
  logic          inc_r, dec_r, done_r, clamped_r, busy_r, ready_r, pwm_reset_r, rst_d_r;

  pwm_period_tick #(.PERIOD(PERIOD)) u_period_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  // Handshake decode; a fresh transfer overrides the latched target for this edge
  always_comb begin
    xfer_s    = tgt_valid && ready_r;
    over_s    = (tgt_duty > DMAX);
    req_s     = over_s ? DMAX : tgt_duty;
    hit_s     = xfer_s && (req_s == cur_r);
    eff_tgt_s = xfer_s ? req_s : tgt_r;
    up_s      = (eff_tgt_s > cur_r);
  end

  // Ramp FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cur_r       <= DRST;
      tgt_r       <= DRST;
      dwell_r     <= {SW{1'b0}};
      inc_r       <= 1'b0;
      dec_r       <= 1'b0;
      done_r      <= 1'b0;
      clamped_r   <= 1'b0;
      busy_r      <= 1'b0;
      ready_r     <= 1'b0;
      pwm_reset_r <= 1'b1;
      rst_d_r     <= 1'b1;
    end else begin
      // generator reset is stretched one cycle past the release
      rst_d_r     <= 1'b0;
      pwm_reset_r <= rst_d_r;
      inc_r       <= 1'b0;
      dec_r       <= 1'b0;
      done_r      <= 1'b0;
      clamped_r   <= xfer_s && over_s;
      if (xfer_s) begin
        tgt_r <= req_s;
      end else begin
        tgt_r <= tgt_r;
      end
      case (state_r)
        IDLE, ALIGN, DWELL: begin
          if (hit_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
          end else if ((state_r == IDLE) && xfer_s) begin
            state_r <= ALIGN;
            busy_r  <= 1'b1;
            ready_r <= RETARGET;
          end else if (tick_s && ((state_r == ALIGN) ||
                                  ((state_r == DWELL) && (dwell_r == DWELL_LAST)))) begin
            state_r <= STEP;
            inc_r   <= up_s;
            dec_r   <= !up_s;
            cur_r   <= up_s ? (cur_r + 1'b1) : (cur_r - 1'b1);
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
          end else if ((state_r == DWELL) && tick_s) begin
            dwell_r <= dwell_r + 1'b1;
          end else if (state_r == IDLE) begin
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        STEP: begin
          busy_r <= 1'b1;
          if (cur_r == tgt_r) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            ready_r <= 1'b0;
          end else begin
            state_r <= DWELL;
            dwell_r <= {SW{1'b0}};
            ready_r <= RETARGET;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign tgt_ready     = ready_r;
  assign increase_duty = inc_r;
  assign decrease_duty = dec_r;
  assign pwm_reset     = pwm_reset_r;
  assign cur_duty      = cur_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign clamped       = clamped_r;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed and random targets against an
// event-schedule reference model (pulse edges on the PERIOD grid, STEP_DIV*PERIOD apart).
module tb_pwm_ramp_ctrl;

  localparam int P    = 10;
  localparam int SD   = 2;
  localparam int DMAX = 10;
  localparam int DRST = 5;
`ifdef PWM_RAMP_RETARGET_EN
  localparam bit RETARGET = 1'b1;
`else
  localparam bit RETARGET = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, tgt_valid, tgt_ready;
  logic       increase_duty, decrease_duty, pwm_reset, busy, done, clamped;
  logic [3:0] tgt_duty, cur_duty;

  int checks = 0;
  int errors = 0;
  int inc_seen = 0;
  int dec_seen = 0;

  // reference model state: n = edges since reset release
  int n, m_next, m_done_edge, m_cur, m_tgt;
  bit m_active;
  bit e_inc, e_dec, e_done, e_clamped, e_busy, e_ready, e_pwm_reset;

  pwm_ramp_ctrl #(
    .PERIOD(P), .DUTY_MAX(DMAX), .DUTY_RESET(DRST), .STEP_DIV(SD), .DW(4)
  ) dut (
    .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_duty(tgt_duty), .increase_duty(increase_duty), .decrease_duty(decrease_duty),
    .pwm_reset(pwm_reset), .cur_duty(cur_duty), .busy(busy), .done(done), .clamped(clamped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, n, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit xfer;
    int t;
    if (reset) begin
      n = 0; m_cur = DRST; m_tgt = DRST; m_active = 1'b0; m_done_edge = -10;
      e_inc = 1'b0; e_dec = 1'b0; e_done = 1'b0; e_clamped = 1'b0;
      e_busy = 1'b0; e_ready = 1'b0; e_pwm_reset = 1'b1;
    end else begin
      n++;
      e_pwm_reset = (n == 1);
      e_inc = 1'b0;
      e_dec = 1'b0;
      xfer = tgt_valid && e_ready;
      t = (int'(tgt_duty) > DMAX) ? DMAX : int'(tgt_duty);
      e_clamped = xfer && (int'(tgt_duty) > DMAX);
      if (xfer) begin
        m_tgt = t;
        if (t == m_cur) begin
          m_active = 1'b0;
          m_done_edge = n;
        end else if (!m_active) begin
          m_active = 1'b1;
          m_next = (n / P + 1) * P;
        end
      end
      if (m_active && n == m_next) begin
        if (m_tgt > m_cur) begin m_cur++; e_inc = 1'b1; end
        else begin m_cur--; e_dec = 1'b1; end
        if (m_cur == m_tgt) begin
          m_active = 1'b0;
          m_done_edge = n + 1;
        end else begin
          m_next = n + SD * P;
        end
      end
      e_done  = (n == m_done_edge);
      e_busy  = m_active || (n <= m_done_edge);
      e_ready = !e_busy || (RETARGET && m_active && !(e_inc || e_dec));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    inc_seen += int'(increase_duty === 1'b1);
    dec_seen += int'(decrease_duty === 1'b1);
    chk("increase_duty", 8'(increase_duty), 8'(e_inc));
    chk("decrease_duty", 8'(decrease_duty), 8'(e_dec));
    chk("pwm_reset", 8'(pwm_reset), 8'(e_pwm_reset));
    chk("cur_duty", 8'(cur_duty), 8'(m_cur));
    chk("tgt_ready", 8'(tgt_ready), 8'(e_ready));
    chk("busy", 8'(busy), 8'(e_busy));
    chk("done", 8'(done), 8'(e_done));
    chk("clamped", 8'(clamped), 8'(e_clamped));
    chk("cur_in_range", 8'(cur_duty <= 4'd10), 8'd1);
    chk("pulse_exclusive", 8'(int'(increase_duty) + int'(decrease_duty) + int'(pwm_reset) <= 1), 8'd1);
  endtask

  task automatic ramp(input logic [3:0] req, input int limit, input bit expect_finish);
    int k;
    int start;
    int t;
    k = 0;
    while (!e_ready && k < 400) begin step(); k++; end
    checks++;
    assert (k < 400) else begin
      errors++;
      $error("FAIL ready_timeout: observed waited %0d cycles expected < 400", k);
    end
    start = m_cur;
    t = (int'(req) > DMAX) ? DMAX : int'(req);
    inc_seen = 0;
    dec_seen = 0;
    tgt_valid = 1'b1;
    tgt_duty = req;
    step();
    tgt_valid = 1'b0;
    k = 0;
    while (e_busy && k < limit) begin step(); k++; end
    if (expect_finish) begin
      step();
      chk("ramp_complete", 8'(busy), 8'd0);
      chk("inc_count", 8'(inc_seen), 8'((t > start) ? t - start : 0));
      chk("dec_count", 8'(dec_seen), 8'((start > t) ? start - t : 0));
      chk("final_duty", 8'(cur_duty), 8'(t));
    end
  endtask

  initial begin
    reset = 1'b1;
    tgt_valid = 1'b0;
    tgt_duty = 4'd0;
    repeat (3) step();
    reset = 1'b0;
    repeat (4) step();

    ramp(4'd5, 400, 1'b1);
    ramp(4'd8, 400, 1'b1);
    ramp(4'd2, 400, 1'b1);
    ramp(4'd13, 400, 1'b1);
    ramp(4'd5, 400, 1'b1);

    // abort a ramp to 9 while it is dwelling between steps
    ramp(4'd9, 25, 1'b0);
    chk("mid_ramp_busy", 8'(busy), 8'd1);
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    inc_seen = 0;
    dec_seen = 0;
    repeat (30) step();
    chk("after_reset_pulses", 8'(inc_seen + dec_seen), 8'd0);
    chk("after_reset_duty", 8'(cur_duty), 8'd5);

    for (int i = 0; i < 5; i++) begin
      ramp(4'($urandom_range(0, 15)), 400, 1'b1);
    end

`ifdef PWM_RAMP_RETARGET_EN
    begin
      int k;
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      repeat (2) step();
      tgt_valid = 1'b1;
      tgt_duty = 4'd9;
      step();
      tgt_valid = 1'b0;
      k = 0;
      while (!(m_cur == 7 && e_ready) && k < 400) begin step(); k++; end
      dec_seen = 0;
      tgt_valid = 1'b1;
      tgt_duty = 4'd6;
      step();
      tgt_valid = 1'b0;
      k = 0;
      while (e_busy && k < 400) begin step(); k++; end
      step();
      chk("retarget_dec_count", 8'(dec_seen), 8'd1);
      chk("retarget_duty", 8'(cur_duty), 8'd6);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
